mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter sharing one single-port synchronous word RAM between up to `N_REQ` requesters: instruction fetch, load/store unit and UART program loader. Accepts one request at a time over a valid/ready handshake, drives the RAM port, and returns a one-cycle response pulse to the winning requester. Sits between the core's multi-cycle FSM, the UART loader and the RAM macro.

## Interface
- `N_REQ`, 3: number of requesters; index 0 is fetch, 1 is load/store, 2 is loader.
- `ADDR_W`, 30: word address width.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_ready` out N_REQ: accept strobe; at most one bit high.
- `req_we` in N_REQ: 1 selects a write, 0 a read.
- `req_addr` in N_REQ*ADDR_W: packed word addresses; requester i occupies slice i.
- `req_wdata` in N_REQ*32: packed write data.
- `req_wmask` in N_REQ*4: packed byte-enable masks.
- `rsp_valid` out N_REQ: one-cycle completion pulse to the granted requester.
- `rsp_rdata` out 32: read data, shared by all requesters, qualified by `rsp_valid`.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 4: RAM byte write enables.
- `mem_addr` out ADDR_W: RAM word address.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid one cycle after the `mem_en` edge.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any `req_valid` is high, the picker selects winner g and drives `req_ready[g]=1`.
  - On the next edge: the payload of g is registered onto `mem_*`, `mem_en` goes to 1, `gnt_idx` goes to g, and the state goes to ACCESS.
- ACCESS:
  - The RAM samples the access on the next edge.
  - `mem_en` goes to 0, `mem_we` goes to 0, and the state goes to RESP.
  - `req_ready` is all-zero.
- RESP:
  - `rsp_valid[gnt_idx]=1`. `rsp_rdata=mem_rdata` (combinational pass-through).
  - A write also pulses `rsp_valid`; `rsp_rdata` is don't-care for writes.
  - The picker runs in this state as it does in IDLE. On an accept the state goes to ACCESS (back-to-back); otherwise it goes to IDLE.
- `mem_we` is `req_wmask` when `req_we` is 1, else 4'b0000.
  - A write with mask 0 performs no RAM update but is still acknowledged.
- Requester obligations:
  - Hold `req_valid` and the payload stable until `req_ready`.
  - Dropping `req_valid` before `req_ready` is legal and has no effect.
- `req_ready` is combinational from `req_valid` and the state. It is never high for a requester whose `req_valid` is 0.
- A requester may raise a new `req_valid` in the same cycle it receives `rsp_valid`. That request can be granted in that cycle.
- Reset, any cycle:
  - State goes to IDLE. `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `rsp_valid=0`. `gnt_idx=0`. Round-robin pointer goes to N_REQ-1.
  - An in-flight access is dropped with no response.

## Timing
- Accept edge E0 → `mem_en` high for the cycle after E0.
- RAM edge E1 → `rsp_valid` high for the cycle after E1.
- Latency from the accept edge to the response cycle is 2 cycles.
- Sustained throughput is one transaction per 2 cycles when requests are back-to-back.
- `mem_*` are registered outputs. `req_ready`, `rsp_valid` and `rsp_rdata` are combinational from state and registers.
- No combinational path exists from `mem_rdata` to `req_ready`.

## Configuration
- Macro `MEM_ARB_ROUND_ROBIN_EN` selects the arbitration policy.
- Defined (round-robin):
  - Search starts at `last_gnt+1` modulo N_REQ.
  - `last_gnt` updates to g on every accept.
  - After reset, requester 0 has the highest priority.
- Undefined (fixed priority):
  - The lowest asserted index always wins.
  - No pointer register is built.

## Structure
- Shared package `soc_pkg` holds:
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2), 2 bits.
  - `MEM_DATA_W=32` and `MEM_MASK_W=4`.
  - Requester index constants `REQ_FETCH=0`, `REQ_LSU=1`, `REQ_LOADER=2`.
- Sub-module `arb_pick`:
  - Combinational and parameterised by N_REQ.
  - Inputs are `req_valid` and a start pointer.
  - Outputs are a one-hot grant and a binary index.
  - A fixed start of 0 gives fixed priority.

## Test plan
- Single read: preload RAM[0x10]=0xDEADBEEF, then `req_valid[0]=1` with addr 0x10.
  - Required: `req_ready[0]` high in the same cycle, `mem_en` high 1 cycle later, `rsp_valid[0]` with 0xDEADBEEF 2 cycles after accept.
- Masked write then read: requester 1 writes 0x11223344 with mask 4'b0101 to addr 0x20, which holds 0xAAAAAAAA; requester 1 then reads addr 0x20.
  - Required: read returns 0xAA22AA44, and the write also got a `rsp_valid[1]` pulse.
- Contention with all three `req_valid` held continuously for 6 grants:
  - With the macro, the grant order is 0,1,2,0,1,2.
  - Without the macro, the grant order is 0,0,0,0,0,0 and requesters 1 and 2 are never granted.
- Back-to-back: requester 0 issues 4 consecutive reads.
  - Required: accepts occur every 2 cycles, and each `rsp_valid` coincides with the next `req_ready`.
- Withdraw: `req_valid[2]` is raised for 1 cycle while in ACCESS, then dropped.
  - Required: no grant is made to requester 2 and no `mem_en` is issued for it.
- Reset mid-access: assert `rst`=0 during ACCESS.
  - Required: `mem_en`, `mem_we` and `rsp_valid` all go to 0 immediately (asynchronously), the state is IDLE, and no response follows after release.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM encoding, RAM widths,
// requester indices and the per-requester write payload.
package soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_MASK_W = 4;

   localparam int REQ_FETCH  = 0;
   localparam int REQ_LSU    = 1;
   localparam int REQ_LOADER = 2;

   typedef struct packed {
      logic                  we;
      logic [MEM_MASK_W-1:0] wmask;
      logic [MEM_DATA_W-1:0] wdata;
   } req_pld_t;

   // Reads must never touch the byte enables, whatever mask the requester left on the bus.
   function automatic logic [MEM_MASK_W-1:0] byte_enables(input req_pld_t pld);
      return pld.we ? pld.wmask : '0;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake plus RAM port bundle for mem_arbiter; slave is the arbiter's view,
// master is the requesters-and-RAM view.
interface mem_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 30
);
   import soc_pkg::*;

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0]            req_we;
   logic [N_REQ*ADDR_W-1:0]     req_addr;
   logic [N_REQ*MEM_DATA_W-1:0] req_wdata;
   logic [N_REQ*MEM_MASK_W-1:0] req_wmask;
   logic [N_REQ-1:0]            rsp_valid;
   logic [MEM_DATA_W-1:0]       rsp_rdata;

   logic                        mem_en;
   logic [MEM_MASK_W-1:0]       mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [MEM_DATA_W-1:0]       mem_wdata;
   logic [MEM_DATA_W-1:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational picker: first asserted request searching upward from start, wrapping at N_REQ.
// Zero latency; tying start to 0 yields fixed lowest-index priority.
module arb_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0] start,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      k   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, start} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
         end
         k = sum[IDX_W-1:0];
         if (!any && req_valid[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM among N_REQ requesters; 2 cycles accept-to-response, 1 txn / 2 cycles.
// Backpressure: req_ready only in IDLE/RESP; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module mem_arbiter
   import soc_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 30
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] start_ptr;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_any;
   logic             pick_en;
   logic             accept;

   logic [ADDR_W-1:0] addr_a [N_REQ];
   req_pld_t          pld_a  [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign pld_a[i]  = '{we:    bus.req_we[i],
                           wmask: bus.req_wmask[i*MEM_MASK_W +: MEM_MASK_W],
                           wdata: bus.req_wdata[i*MEM_DATA_W +: MEM_DATA_W]};
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_gnt;

   // Reset value N_REQ-1 makes requester 0 the first in line after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt <= IDX_W'(N_REQ - 1);
      end else if (accept) begin
         last_gnt <= pick_idx;
      end
   end

   assign start_ptr = (last_gnt == IDX_W'(N_REQ - 1)) ? '0 : last_gnt + IDX_W'(1);
`else
   assign start_ptr = '0;
`endif

   arb_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_valid (bus.req_valid),
      .start     (start_ptr),
      .gnt       (pick_gnt),
      .idx       (pick_idx),
      .any       (pick_any)
   );

   // Picking in RESP as well as IDLE is what allows back-to-back grants.
   assign pick_en       = (state == ST_IDLE) || (state == ST_RESP);
   assign accept        = pick_en && pick_any;
   assign bus.req_ready = pick_en ? pick_gnt : '0;
   assign bus.rsp_rdata = bus.mem_rdata;

   always_comb begin
      bus.rsp_valid = '0;
      if (state == ST_RESP) begin
         bus.rsp_valid[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         gnt_idx       <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  state         <= ST_ACCESS;
                  gnt_idx       <= pick_idx;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= byte_enables(pld_a[pick_idx]);
                  bus.mem_addr  <= addr_a[pick_idx];
                  bus.mem_wdata <= pld_a[pick_idx].wdata;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               state      <= ST_RESP;
               bus.mem_en <= 1'b0;
               bus.mem_we <= '0;
            end
            default: begin
               state      <= ST_IDLE;
               bus.mem_en <= 1'b0;
               bus.mem_we <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 256-word RAM; build with or without
// MEM_ARB_ROUND_ROBIN_EN, the contention expectations follow the macro.
module tb_mem_arbiter;
   import soc_pkg::*;

   localparam int N  = 3;
   localparam int AW = 30;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

   mem_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          idx;
      bit          we;
      logic [31:0] data;
   } exp_t;

   exp_t exp_rsp[$];
   int   exp_gnt[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // RAM model: one-cycle read latency, byte-masked writes, preloaded once.
   logic [31:0] ram [256];
   bit          loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int a = 0; a < 256; a++) ram[a] <= 32'h0;
         ram[8'h10] <= 32'hDEADBEEF;
         ram[8'h20] <= 32'hAAAAAAAA;
         ram[8'h30] <= 32'h12345678;
         ram[8'h40] <= 32'h0BADF00D;
         loaded     <= 1'b1;
      end else if (bus.mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_we[b]) ram[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end
         bus.mem_rdata <= ram[bus.mem_addr[7:0]];
      end
   end

   // Monitor: grants, RAM strobe one cycle after accept, responses two cycles after accept.
   logic          mem_pend = 1'b0;
   logic [AW-1:0] pend_addr;
   logic [3:0]    pend_we;
   time           last_acc = 0;
   exp_t          e;
   int            g;

   always @(negedge clk) begin
      if (!rst) begin
         mem_pend = 1'b0;
      end else begin
         if (mem_pend) begin
            chk("mem_en_after_accept", 64'(bus.mem_en), 64'd1);
            chk("mem_addr", 64'(bus.mem_addr), 64'(pend_addr));
            chk("mem_we", 64'(bus.mem_we), 64'(pend_we));
            mem_pend = 1'b0;
         end
         if (bus.rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
               chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
               e = exp_rsp.pop_front();
               chk("rsp_idx", 64'(bus.rsp_valid), 64'(3'b001 << e.idx));
               if (!e.we) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
               chk("rsp_latency", 64'($time - last_acc), 64'd20);
            end
         end
         if (bus.req_ready != '0) begin
            g = 0;
            for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
            chk("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
            chk("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
            if (exp_gnt.size() == 0) chk("unexpected_grant", 64'(bus.req_ready), 64'd0);
            else                     chk("grant_idx", 64'(g), 64'(exp_gnt.pop_front()));
            last_acc  = $time;
            mem_pend  = 1'b1;
            pend_addr = bus.req_addr[g*AW +: AW];
            pend_we   = bus.req_we[g] ? bus.req_wmask[g*4 +: 4] : 4'h0;
         end
      end
   end

   task automatic set_pld(input int i, input bit we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
      bus.req_we[i]           = we;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_wdata[i*32 +: 32] = d;
      bus.req_wmask[i*4 +: 4]   = m;
   endtask

   task automatic wait_rdy(input int i, output int waits);
      waits = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         waits++;
         if (bus.req_ready[i]) return;
      end
      chk("ready_timeout", 64'(bus.req_ready[i]), 64'd1);
   endtask

   task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] ex, output int waits);
      exp_gnt.push_back(i);
      exp_rsp.push_back('{idx: i, we: we, data: ex});
      set_pld(i, we, a, d, m);
      bus.req_valid[i] = 1'b1;
      wait_rdy(i, waits);
      @(posedge clk);
      #1 bus.req_valid[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   logic [AW-1:0] b2b_addr [4] = '{30'h10, 30'h20, 30'h30, 30'h40};
   logic [31:0]   b2b_data [4] = '{32'hDEADBEEF, 32'hAA22AA44, 32'h12345678, 32'h0BADF00D};
   logic [31:0]   rd_of    [3] = '{32'hDEADBEEF, 32'hAAAAAAAA, 32'h12345678};
`ifdef MEM_ARB_ROUND_ROBIN_EN
   int cont_order [6] = '{0, 1, 2, 0, 1, 2};
`else
   int cont_order [6] = '{0, 0, 0, 0, 0, 0};
`endif

   initial begin
      int  w;
      int  acc;
      time t_prev;

      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wmask = '0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Contention: all three held for six grants
      for (int k = 0; k < 6; k++) begin
         exp_gnt.push_back(cont_order[k]);
         exp_rsp.push_back('{idx: cont_order[k], we: 1'b0, data: rd_of[cont_order[k]]});
      end
      set_pld(0, 1'b0, 30'h10, 32'h0, 4'h0);
      set_pld(1, 1'b0, 30'h20, 32'h0, 4'h0);
      set_pld(2, 1'b0, 30'h30, 32'h0, 4'h0);
      bus.req_valid = 3'b111;
      acc = 0;
      for (int n = 0; n < 40 && acc < 6; n++) begin
         @(negedge clk);
         if (bus.req_ready != '0) acc++;
      end
      chk("contention_grant_count", 64'(acc), 64'd6);
      @(posedge clk);
      #1 bus.req_valid = '0;
      repeat (4) @(posedge clk);
      #1;

      // Single read: ready in the same cycle as valid
      issue(0, 1'b0, 30'h10, 32'h0, 4'h0, 32'hDEADBEEF, w);
      chk("rd_ready_same_cycle", 64'(w), 64'd1);

      // Masked write then read-back
      issue(1, 1'b1, 30'h20, 32'h11223344, 4'b0101, 32'h0, w);
      issue(1, 1'b0, 30'h20, 32'h0, 4'h0, 32'hAA22AA44, w);

      // Back-to-back reads from requester 0
      for (int k = 0; k < 4; k++) begin
         exp_gnt.push_back(0);
         exp_rsp.push_back('{idx: 0, we: 1'b0, data: b2b_data[k]});
      end
      set_pld(0, 1'b0, b2b_addr[0], 32'h0, 4'h0);
      bus.req_valid[0] = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_rdy(0, w);
         if (k > 0) begin
            chk("b2b_spacing", 64'($time - t_prev), 64'd20);
            chk("b2b_rsp_with_ready", 64'(bus.rsp_valid[0]), 64'd1);
         end
         t_prev = $time;
         @(posedge clk);
         #1;
         if (k < 3) set_pld(0, 1'b0, b2b_addr[k+1], 32'h0, 4'h0);
         else       bus.req_valid[0] = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;

      // Withdraw: requester 2 pulses valid only during ACCESS
      exp_gnt.push_back(0);
      exp_rsp.push_back('{idx: 0, we: 1'b0, data: 32'hDEADBEEF});
      set_pld(0, 1'b0, 30'h10, 32'h0, 4'h0);
      bus.req_valid[0] = 1'b1;
      wait_rdy(0, w);
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      set_pld(2, 1'b0, 30'h30, 32'h0, 4'h0);
      bus.req_valid[2] = 1'b1;
      @(negedge clk);
      chk("withdraw_no_ready_in_access", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1 bus.req_valid[2] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("withdraw_grants_pending", 64'(exp_gnt.size()), 64'd0);

      // Reset during ACCESS of a full-mask write
      exp_gnt.push_back(0);
      set_pld(0, 1'b1, 30'h40, 32'hFFFFFFFF, 4'hF);
      bus.req_valid[0] = 1'b1;
      wait_rdy(0, w);
      @(posedge clk);
      #1 bus.req_valid[0] = 1'b0;
      chk("pre_rst_mem_en", 64'(bus.mem_en), 64'd1);
      chk("pre_rst_mem_we", 64'(bus.mem_we), 64'hF);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("async_rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("async_rst_state", 64'(dut.state), 64'(ST_IDLE));
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      // Dropped write must not have reached the RAM
      issue(0, 1'b0, 30'h40, 32'h0, 4'h0, 32'h0BADF00D, w);

      chk("grants_outstanding", 64'(exp_gnt.size()), 64'd0);
      chk("responses_outstanding", 64'(exp_rsp.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
